csi2_raw10_packer: RTL

Packs 10-bit Bayer pixels from `image_generator` into the 64-bit byte-data stream consumed by the `csi2_output` CSI-2 TX core, using CSI-2 RAW10 packing: 4 pixels → 5 bytes. It sits between the pixel source and the byte interface in the byte-clock domain. It absorbs the 5-byte/8-byte width mismatch in a small accumulator, zero-pads each line to a 64-bit boundary, and reports the unpadded line byte count for the packet-header word count.

---
 rtl/csi2_pkg.sv | 16 +
 rtl/raw10_group_pack.sv | 21 ++
 rtl/csi2_raw10_packer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 TX definitions: RAW10 packing constants,
// packer state encoding and the RAW10 data type code.
package csi2_pkg;

    localparam int GROUP_BYTES = 5;
    localparam int WORD_BYTES  = 8;
    localparam int BUF_BYTES   = 12;

    localparam logic [5:0] DT_RAW10 = 6'h2B;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

endpackage

// File: rtl/raw10_group_pack.sv
// RAW10 group formation: four 10-bit pixels become five bytes,
// MSBs first, the four LSB pairs collected in the fifth byte.
module raw10_group_pack
    import csi2_pkg::*;
(
    input  logic [9:0]               pix0_i,
    input  logic [9:0]               pix1_i,
    input  logic [9:0]               pix2_i,
    input  logic [9:0]               pix3_i,
    output logic [GROUP_BYTES*8-1:0] group_o
);

    assign group_o = {
        pix3_i[1:0], pix2_i[1:0], pix1_i[1:0], pix0_i[1:0],
        pix3_i[9:2],
        pix2_i[9:2],
        pix1_i[9:2],
        pix0_i[9:2]
    };

endmodule

// File: rtl/csi2_raw10_packer.sv
// RAW10 pixel-group to 64-bit byte-word packer with per-line padding.
// Optional line length check: CSI2_RAW10_PACKER_LINE_CHECK_EN.
module csi2_raw10_packer
    import csi2_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        byte_clk_i,
    input  logic        reset_n_i,
    input  logic [9:0]  pix0_i,
    input  logic [9:0]  pix1_i,
    input  logic [9:0]  pix2_i,
    input  logic [9:0]  pix3_i,
    input  logic        pix_valid_i,
    input  logic        line_end_i,
    output logic        pix_ready_o,
    output logic [63:0] byte_data_o,
    output logic        byte_data_en_o,
    input  logic        ld_pyld_i,
`ifdef CSI2_RAW10_PACKER_LINE_CHECK_EN
    input  logic [15:0] expected_wc_i,
    output logic        wc_err_o,
`endif
    output logic        line_done_o,
    output logic [15:0] line_bytes_o
);

    localparam int BUF_W  = BUF_BYTES * 8;
    localparam int WORD_W = WORD_BYTES * 8;
    localparam int GRP_W  = GROUP_BYTES * 8;

    pack_state_e      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_shift;
    logic [3:0]       fill_q, fill_d, fill_left;
    logic [GRP_W-1:0] group;
    logic [WORD_W-1:0] word_pad;
    logic [15:0]      cnt_q, cnt_next, line_bytes_q;
    logic             xfer, accept, last_xfer, flush_entry;
    logic             line_done_q;

    raw10_group_pack u_group_pack (
        .pix0_i  (pix0_i),
        .pix1_i  (pix1_i),
        .pix2_i  (pix2_i),
        .pix3_i  (pix3_i),
        .group_o (group)
    );

    assign byte_data_en_o = (fill_q >= 4'd8) ||
                            (state_q == FLUSH && fill_q != 4'd0);
    assign xfer   = byte_data_en_o & ld_pyld_i;
    assign pix_ready_o = reset_n_i & (state_q == RUN) &
                         ((fill_q <= 4'd7) | xfer);
    assign accept = pix_valid_i & pix_ready_o;

    // Remove the word leaving this cycle before appending new bytes.
    assign fill_left = !xfer ? fill_q :
                       (fill_q > 4'd8) ? fill_q - 4'd8 : 4'd0;
    assign buf_shift = xfer ? (buf_q >> WORD_W) : buf_q;
    assign cnt_next  = cnt_q + 16'(GROUP_BYTES);

    // Low word of the buffer with unfilled bytes forced to the pad value.
    always_comb begin
        word_pad = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            word_pad[i*8 +: 8] = (4'(i) < fill_q) ?
                                 buf_q[i*8 +: 8] : PAD_BYTE;
        end
    end

    assign byte_data_o = byte_data_en_o ? word_pad : '0;

    // Next buffer contents, fill level and line state.
    always_comb begin
        buf_d       = buf_shift;
        fill_d      = fill_left;
        state_d     = state_q;
        last_xfer   = 1'b0;
        flush_entry = 1'b0;
        if (accept) begin
            buf_d  = buf_shift |
                     (BUF_W'(group) << {fill_left, 3'b000});
            fill_d = fill_left + 4'(GROUP_BYTES);
        end
        unique case (state_q)
            RUN: begin
                if (accept && line_end_i) begin
                    state_d     = FLUSH;
                    flush_entry = 1'b1;
                end
            end
            FLUSH: begin
                if (xfer && fill_left == 4'd0) begin
                    state_d   = RUN;
                    last_xfer = 1'b1;
                end
            end
        endcase
    end

    // Buffer, fill level and state registers.
    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    // Line byte counter, latched length and end-of-line pulse.
    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q        <= '0;
            line_bytes_q <= '0;
            line_done_q  <= 1'b0;
        end else begin
            line_done_q <= last_xfer;
            if (flush_entry) begin
                line_bytes_q <= cnt_next;
                cnt_q        <= '0;
            end else if (accept) begin
                cnt_q <= cnt_next;
            end
        end
    end

    assign line_done_o  = line_done_q;
    assign line_bytes_o = line_bytes_q;

`ifdef CSI2_RAW10_PACKER_LINE_CHECK_EN
    logic wc_err_q;

    // Sticky flag for a line length differing from the expected count.
    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wc_err_q <= 1'b0;
        end else if (flush_entry && cnt_next != expected_wc_i) begin
            wc_err_q <= 1'b1;
        end
    end

    assign wc_err_o = wc_err_q;
`endif

endmodule
